// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, the
// per-stage control bundle, and the RUN-mode priority resolver.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT      = 2'd0,
    RUN       = 2'd1,
    DMEM_WAIT = 2'd2,
    HALT      = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctrl_t;

  // Branch beats load-use stall, which beats an instruction-fetch miss.
  function automatic stage_ctrl_t resolve_ctrl(input logic branch,
                                               input logic stall,
                                               input logic imem_ready);
    stage_ctrl_t c;
    c = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
          id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1};
    if (branch) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (stall) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end else if (!imem_ready) begin
      c.pc_en       = 1'b0;
      c.if_id_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer: merges hazard, branch, memory-handshake and
// halt conditions into per-stage enables/flushes, with saturating perf counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int INIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall_IF_ID,
  input  logic             EX_BranchTaken,
  input  logic             IMEM_Ready,
  input  logic             DMEM_Req,
  input  logic             DMEM_Ready,
  input  logic             WB_Halt,
  output logic             PC_En,
  output logic             IF_ID_En,
  output logic             IF_ID_Flush,
  output logic             ID_EX_En,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_En,
  output logic             MEM_WB_En,
  output logic             Halted,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic        halted_q, halted_d;
  stage_ctrl_t ctrl;
  logic        stall_inc, flush_inc;
  logic        mem_blocked;

  always_comb begin
    ctrl        = '0;
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    halted_d    = halted_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    mem_blocked = 1'b0;
    unique case (state_q)
      INIT: begin
        ctrl.if_id_flush = 1'b1;
        ctrl.id_ex_flush = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end
      RUN, DMEM_WAIT: begin
        // A fresh request is only examined from RUN; in DMEM_WAIT the pending one is.
        mem_blocked = !DMEM_Ready && ((state_q == DMEM_WAIT) || DMEM_Req);
        if (mem_blocked) begin
          state_d = DMEM_WAIT;
        end else begin
          state_d   = RUN;
          ctrl      = resolve_ctrl(EX_BranchTaken, Stall_IF_ID, IMEM_Ready);
          flush_inc = EX_BranchTaken;
        end
        stall_inc = !ctrl.pc_en;
        if (WB_Halt && ctrl.mem_wb_en) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end
      end
      HALT: begin
        ctrl = '0;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      halted_q   <= halted_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (stall_inc),
    .count (Stall_Cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (flush_inc),
    .count (Flush_Cnt)
  );

  assign PC_En       = ctrl.pc_en;
  assign IF_ID_En    = ctrl.if_id_en;
  assign IF_ID_Flush = ctrl.if_id_flush;
  assign ID_EX_En    = ctrl.id_ex_en;
  assign ID_EX_Flush = ctrl.id_ex_flush;
  assign EX_MEM_En   = ctrl.ex_mem_en;
  assign MEM_WB_En   = ctrl.mem_wb_en;
  assign Halted      = halted_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised bench for pipeline_ctrl: a behavioural model is compared every
// negedge, plus directed literal checks for reset, stall, branch, DMEM, halt, saturation.
module tb_pipeline_ctrl;

  localparam int CNT_W       = 4;
  localparam int INIT_CYCLES = 2;
  localparam int CMAX        = (1 << CNT_W) - 1;

  // Control vector order: PC, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush, EX_MEM, MEM_WB
  localparam logic [6:0] V_INIT  = 7'b0010100;
  localparam logic [6:0] V_NOM   = 7'b1101011;
  localparam logic [6:0] V_BR    = 7'b1111111;
  localparam logic [6:0] V_STALL = 7'b0001111;
  localparam logic [6:0] V_IMISS = 7'b0111011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Stall_IF_ID = 1'b0, EX_BranchTaken = 1'b0, IMEM_Ready = 1'b1;
  logic DMEM_Req = 1'b0, DMEM_Ready = 1'b0, WB_Halt = 1'b0;
  logic PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush, EX_MEM_En, MEM_WB_En, Halted;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .INIT_CYCLES(INIT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .Stall_IF_ID(Stall_IF_ID), .EX_BranchTaken(EX_BranchTaken), .IMEM_Ready(IMEM_Ready),
    .DMEM_Req(DMEM_Req), .DMEM_Ready(DMEM_Ready), .WB_Halt(WB_Halt),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .IF_ID_Flush(IF_ID_Flush), .ID_EX_En(ID_EX_En),
    .ID_EX_Flush(ID_EX_Flush), .EX_MEM_En(EX_MEM_En), .MEM_WB_En(MEM_WB_En),
    .Halted(Halted), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dut_vec();
    return {PC_En, IF_ID_En, IF_ID_Flush, ID_EX_En, ID_EX_Flush, EX_MEM_En, MEM_WB_En};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = filling, 1 = running, 2 = waiting on data memory, 3 = frozen
  int m_mode = 0, m_left = INIT_CYCLES, m_stall = 0, m_flush = 0, m_halted = 0;
  int n_mode = 0, n_left = INIT_CYCLES, n_stall = 0, n_flush = 0, n_halted = 0;

  always @(negedge clk) begin
    logic [6:0] e;
    e = V_INIT;
    n_mode = m_mode; n_left = m_left; n_stall = m_stall;
    n_flush = m_flush; n_halted = m_halted;
    if (!rst) begin
      if (m_mode == 0) begin
        if (m_left <= 1) n_mode = 1;
        else n_left = m_left - 1;
      end else if (m_mode == 3) begin
        e = 7'b0;
      end else begin
        if (!DMEM_Ready && (m_mode == 2 || DMEM_Req)) begin
          e = 7'b0;
          n_mode = 2;
        end else begin
          n_mode = 1;
          if (EX_BranchTaken) begin
            e = V_BR;
            n_flush = (m_flush >= CMAX) ? CMAX : m_flush + 1;
          end else if (Stall_IF_ID) e = V_STALL;
          else if (!IMEM_Ready)     e = V_IMISS;
          else                      e = V_NOM;
        end
        if (e[6] == 1'b0) n_stall = (m_stall >= CMAX) ? CMAX : m_stall + 1;
        if (WB_Halt && e[0]) begin
          n_mode = 3;
          n_halted = 1;
        end
      end
    end
    chk("ctrl", int'(dut_vec()), int'(e));
    chk("halted", int'(Halted), m_halted);
    chk("stall_cnt", int'(Stall_Cnt), m_stall);
    chk("flush_cnt", int'(Flush_Cnt), m_flush);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_left <= INIT_CYCLES; m_stall <= 0; m_flush <= 0; m_halted <= 0;
    end else begin
      m_mode <= n_mode; m_left <= n_left; m_stall <= n_stall;
      m_flush <= n_flush; m_halted <= n_halted;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nominal();
    Stall_IF_ID = 0; EX_BranchTaken = 0; IMEM_Ready = 1;
    DMEM_Req = 0; DMEM_Ready = 0; WB_Halt = 0;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    nominal();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic run_to_ready();
    do_reset();
    tick();
    tick();
  endtask

  initial begin
    // Reset and fill
    nominal();
    rst = 1;
    tick();
    mid();
    chk("rst_ctrl", int'(dut_vec()), int'(V_INIT));
    chk("rst_stall", int'(Stall_Cnt), 0);
    chk("rst_flush", int'(Flush_Cnt), 0);
    tick();
    rst = 0;
    mid(); chk("init_c1", int'(dut_vec()), int'(V_INIT)); tick();
    mid(); chk("init_c2", int'(dut_vec()), int'(V_INIT)); tick();
    mid(); chk("run_nom", int'(dut_vec()), int'(V_NOM));
    tick();

    // Single load-use stall
    Stall_IF_ID = 1;
    mid(); chk("stall_ctrl", int'(dut_vec()), int'(V_STALL));
    chk("stall_cnt_pre", int'(Stall_Cnt), 0);
    tick(); nominal();
    chk("stall_cnt_post", int'(Stall_Cnt), 1);

    // Branch overrides stall and fetch miss
    Stall_IF_ID = 1; EX_BranchTaken = 1; IMEM_Ready = 0;
    mid(); chk("br_ctrl", int'(dut_vec()), int'(V_BR));
    tick(); nominal();
    chk("br_flush_cnt", int'(Flush_Cnt), 1);
    chk("br_stall_cnt", int'(Stall_Cnt), 1);

    // Data memory wait of three cycles
    DMEM_Req = 1; DMEM_Ready = 0;
    for (int i = 0; i < 3; i++) begin
      mid(); chk("dmem_wait", int'(dut_vec()), 0);
      tick();
    end
    DMEM_Ready = 1;
    mid(); chk("dmem_done", int'(dut_vec()), int'(V_NOM));
    tick(); nominal();
    chk("dmem_stall_cnt", int'(Stall_Cnt), 4);

    // Halt in RUN, then frozen regardless of inputs, then async reset
    WB_Halt = 1;
    tick(); nominal();
    for (int i = 0; i < 10; i++) begin
      Stall_IF_ID = 1'($urandom); EX_BranchTaken = 1'($urandom); IMEM_Ready = 1'($urandom);
      DMEM_Req = 1'($urandom); DMEM_Ready = 1'($urandom); WB_Halt = 1'($urandom);
      mid();
      chk("halt_ctrl", int'(dut_vec()), 0);
      chk("halt_flag", int'(Halted), 1);
      tick();
    end
    mid();
    #2 rst = 1;
    #1;
    chk("async_rst_ctrl", int'(dut_vec()), int'(V_INIT));
    chk("async_rst_halted", int'(Halted), 0);
    chk("async_rst_cnt", int'(Stall_Cnt), 0);
    tick();
    rst = 0;
    nominal();

    // Randomised traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 80) == 0 || (m_mode == 3 && $urandom_range(0, 5) == 0)) begin
        do_reset();
      end
      Stall_IF_ID    = ($urandom_range(0, 3) == 0);
      EX_BranchTaken = ($urandom_range(0, 5) == 0);
      IMEM_Ready     = ($urandom_range(0, 3) != 0);
      DMEM_Req       = ($urandom_range(0, 2) == 0);
      DMEM_Ready     = 1'($urandom);
      WB_Halt        = ($urandom_range(0, 40) == 0);
      tick();
    end

    // Stall counter saturation
    run_to_ready();
    Stall_IF_ID = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", int'(Stall_Cnt), CMAX);
    tick(); tick();
    chk("sat_hold", int'(Stall_Cnt), CMAX);
    nominal();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
